eq_filter_ctrl: RTL and testbench
=================================

EQ_FILTER_CTRL -- requirements
Module: eq_filter_ctrl

Interface
REQ-001 Parameter NTAPS, default 16: filter tap count, power of two, 2..64.
REQ-002 Parameter FLT_LAT, default 1: cycles from filter input strobe to valid filter output, 1..8.
REQ-003 Parameter W, default 16: sample and coefficient width, two's complement.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_start  in  1  request coefficient load; SHALL be honoured only in IDLE.
REQ-007 cfg_valid / cfg_coef  in  1 / W  coefficient word offer.
REQ-008 cfg_ready  out  1  coefficient accept; transfer when cfg_valid&cfg_ready.
REQ-009 coef_we / coef_addr / coef_wdata  out  1 / log2(NTAPS) / W  tap write port to filter.
REQ-010 run_en  in  1  level request to stream samples.
REQ-011 s_valid / s_data  in  1 / W  input sample offer; s_ready  out  1  accept.
REQ-012 flt_en / flt_xn  out  1 / W  filter input strobe and sample (drives filter xn).
REQ-013 flt_yn  in  W  filter output.
REQ-014 m_valid / m_data  out  1 / W  equalised output; no backpressure.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN, FLUSH.
REQ-017 IDLE: cfg_start -> LOAD; else run_en -> RUN; cfg_start SHALL win when both are high.
REQ-018 LOAD: cfg_ready=1; each transfer SHALL drive coef_we=1, coef_wdata=cfg_coef, coef_addr=tap counter, all registered, one cycle after the transfer.
REQ-019 Tap counter SHALL start at 0, increment per transfer; the transfer at NTAPS-1 SHALL return to IDLE and reset the counter to 0; no wrap beyond NTAPS-1.
REQ-020 RUN: s_ready=1; a handshake in cycle H SHALL produce flt_en=1, flt_xn=s_data in cycle H+1; otherwise flt_en=0, flt_xn holds its last value.
REQ-021 RUN with run_en=0 SHALL go to FLUSH; a sample offered in that same cycle SHALL still be accepted.
REQ-022 FLUSH: s_ready=0; SHALL issue exactly NTAPS-1 consecutive strobes with flt_xn=0, then go to IDLE.
REQ-023 cfg_start and run_en SHALL be ignored in LOAD and FLUSH; cfg_start ignored in RUN.
REQ-024 m_valid SHALL equal flt_en delayed FLT_LAT+1 cycles; m_data SHALL be flt_yn sampled FLT_LAT cycles after the strobe, registered; m_data holds when m_valid=0.
REQ-025 Output count SHALL equal strobe count; flush strobes SHALL produce outputs.
REQ-026 cfg_ready and s_ready SHALL never be high together.

Reset
REQ-027 rst=1 SHALL force state IDLE, tap counter 0 and delay line cleared; cfg_ready, s_ready, coef_we, flt_en, m_valid, busy all 0; coef_addr, coef_wdata, flt_xn, m_data 0.
REQ-028 rst in LOAD SHALL abandon the load with no further coef_we; already-written taps are not cleared.
REQ-029 rst in RUN or FLUSH SHALL discard in-flight valids; no m_valid for pre-reset strobes.

Structure
REQ-030 Package eq_pkg SHALL hold the state enum, default W, NTAPS and FLT_LAT constants.
REQ-031 Valid/data delay line SHALL be sub-module eq_valid_pipe (parameter DEPTH); FSM and counters stay in eq_filter_ctrl.

Verification
REQ-032 Reset: hold rst 3 cycles in RUN with s_valid=1 -> all outputs 0, busy=0, no m_valid afterwards.
REQ-033 Load: cfg_start, then 16 words 0x0001..0x0010 with cfg_valid gaps -> coef_we x16, addr 0..15 in order, data matches, IDLE after last, busy 0.
REQ-034 Stream: run_en=1, 8 samples 100,-200,...; FLT_LAT=1 -> flt_en at H+1, m_valid at H+3 for each, 8 outputs in order.
REQ-035 Stop/flush: drop run_en with s_valid=1 -> that sample accepted, then 15 zero strobes, 15 extra m_valid, IDLE.
REQ-036 Priority: cfg_start and run_en high together in IDLE -> LOAD entered, s_ready stays 0.
REQ-037 Mid-load reset: rst after 5 words -> no coef_we after reset; new load restarts at coef_addr 0.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and default sizing for the equaliser filter controller.
package eq_pkg;

  localparam int W_DEF       = 16;
  localparam int NTAPS_DEF   = 16;
  localparam int FLT_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/eq_valid_pipe.sv
// Valid delay line with a registered data capture on its last stage:
// out_valid is in_valid delayed DEPTH cycles, out_data is in_data taken DEPTH-1 cycles after the strobe.
module eq_valid_pipe
  import eq_pkg::*;
#(
  parameter int DEPTH = FLT_LAT_DEF + 1,
  parameter int W     = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-2:0] tap_sr;
  logic             tap;

  // tap marks the cycle in which in_data carries the result for the strobe
  assign tap = tap_sr[DEPTH-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_sr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      for (int i = DEPTH - 2; i > 0; i--) begin
        tap_sr[i] <= tap_sr[i-1];
      end
      tap_sr[0] <= in_valid;
      out_valid <= tap;
      if (tap) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/eq_filter_ctrl.sv
// Equaliser filter controller: coefficient load sequencing, sample streaming
// into an external filter and flush of its delay line when streaming stops.
//  state | meaning
//  IDLE  | waiting for cfg_start (has priority) or run_en
//  LOAD  | accepting NTAPS coefficient words, one tap write per transfer
//  RUN   | forwarding accepted samples to the filter
//  FLUSH | NTAPS-1 zero strobes push the last samples through the taps
module eq_filter_ctrl
  import eq_pkg::*;
#(
  parameter int  NTAPS   = NTAPS_DEF,
  parameter int  FLT_LAT = FLT_LAT_DEF,
  parameter int  W       = W_DEF,
  localparam int AW      = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic [W-1:0]  cfg_coef,
  output logic          cfg_ready,
  output logic          coef_we,
  output logic [AW-1:0] coef_addr,
  output logic [W-1:0]  coef_wdata,
  input  logic          run_en,
  input  logic          s_valid,
  input  logic [W-1:0]  s_data,
  output logic          s_ready,
  output logic          flt_en,
  output logic [W-1:0]  flt_xn,
  input  logic [W-1:0]  flt_yn,
  output logic          m_valid,
  output logic [W-1:0]  m_data,
  output logic          busy
);

  localparam logic [AW-1:0] TAP_LAST = AW'(NTAPS - 1);
  localparam logic [AW-1:0] FLUSH_TC = AW'(NTAPS - 2);

  state_t        state, state_nxt;
  logic [AW-1:0] tap_cnt, tap_cnt_nxt;
  logic [AW-1:0] flush_cnt, flush_cnt_nxt;
  logic          coef_we_nxt;
  logic [AW-1:0] coef_addr_nxt;
  logic [W-1:0]  coef_wdata_nxt;
  logic          flt_en_nxt;
  logic [W-1:0]  flt_xn_nxt;

  // Ready/busy are gated by rst so they drop in the very cycle reset is seen
  assign cfg_ready = (state == LOAD) && !rst;
  assign s_ready   = (state == RUN) && !rst;
  assign busy      = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      flush_cnt  <= '0;
      coef_we    <= 1'b0;
      coef_addr  <= '0;
      coef_wdata <= '0;
      flt_en     <= 1'b0;
      flt_xn     <= '0;
    end else begin
      state      <= state_nxt;
      tap_cnt    <= tap_cnt_nxt;
      flush_cnt  <= flush_cnt_nxt;
      coef_we    <= coef_we_nxt;
      coef_addr  <= coef_addr_nxt;
      coef_wdata <= coef_wdata_nxt;
      flt_en     <= flt_en_nxt;
      flt_xn     <= flt_xn_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    tap_cnt_nxt    = tap_cnt;
    flush_cnt_nxt  = flush_cnt;
    coef_we_nxt    = 1'b0;
    coef_addr_nxt  = coef_addr;
    coef_wdata_nxt = coef_wdata;
    flt_en_nxt     = 1'b0;
    flt_xn_nxt     = flt_xn;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = LOAD;
        end else if (run_en) begin
          state_nxt = RUN;
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          coef_we_nxt    = 1'b1;
          coef_addr_nxt  = tap_cnt;
          coef_wdata_nxt = cfg_coef;
          if (tap_cnt == TAP_LAST) begin
            tap_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            tap_cnt_nxt = tap_cnt + AW'(1);
          end
        end
      end
      RUN: begin
        if (s_valid) begin
          flt_en_nxt = 1'b1;
          flt_xn_nxt = s_data;
        end
        if (!run_en) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_TC;
        end
      end
      FLUSH: begin
        flt_en_nxt = 1'b1;
        flt_xn_nxt = '0;
        if (flush_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt - AW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  eq_valid_pipe #(
    .DEPTH (FLT_LAT + 1),
    .W     (W)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (flt_en),
    .in_data   (flt_yn),
    .out_valid (m_valid),
    .out_data  (m_data)
  );

endmodule

// File: tb/tb_eq_filter_ctrl.sv
// Self-checking bench for eq_filter_ctrl: scoreboard queues for tap writes,
// filter strobes and equalised outputs, plus directed load/stream/reset sequences.
module tb_eq_filter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_valid, cfg_ready;
  logic [15:0] cfg_coef;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        run_en, s_valid, s_ready;
  logic [15:0] s_data;
  logic        flt_en;
  logic [15:0] flt_xn;
  logic [15:0] flt_yn = 16'h0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cyc = 0;

  typedef struct {
    logic [15:0] d;
    logic [15:0] a;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        v;
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  exp_t coef_q[$];
  exp_t strb_q[$];
  exp_t out_q[$];
  vec_t vec[10];

  logic [15:0] last_xn = 16'h0;
  logic [15:0] last_m  = 16'h0;

  eq_filter_ctrl #(.NTAPS(16), .FLT_LAT(1), .W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_coef   (cfg_coef),
    .cfg_ready  (cfg_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .run_en     (run_en),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .flt_en     (flt_en),
    .flt_xn     (flt_xn),
    .flt_yn     (flt_yn),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Filter model with one cycle latency: y = 3x+1 for strobed samples, junk otherwise
  always @(posedge clk) flt_yn <= flt_en ? (flt_xn * 16'd3 + 16'd1) : 16'hDEAD;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cfg_ready"},  32'(cfg_ready),  0);
    check({tag, "_s_ready"},    32'(s_ready),    0);
    check({tag, "_coef_we"},    32'(coef_we),    0);
    check({tag, "_flt_en"},     32'(flt_en),     0);
    check({tag, "_m_valid"},    32'(m_valid),    0);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_coef_addr"},  32'(coef_addr),  0);
    check({tag, "_coef_wdata"}, 32'(coef_wdata), 0);
    check({tag, "_flt_xn"},     32'(flt_xn),     0);
    check({tag, "_m_data"},     32'(m_data),     0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_xn = 16'h0;
      last_m  = 16'h0;
    end else begin
      check("rdy_excl", 32'(s_ready & cfg_ready), 0);
      if (coef_we) begin
        if (coef_q.size() == 0) check("coef_we_unexp", 32'(coef_we), 0);
        else begin
          e = coef_q.pop_front();
          check("coef_addr", 32'(coef_addr), 32'(e.a));
          check("coef_wdata", 32'(coef_wdata), 32'(e.d));
          check("coef_cyc", cyc, e.cyc);
        end
      end
      if (flt_en) begin
        if (strb_q.size() == 0) check("flt_en_unexp", 32'(flt_en), 0);
        else begin
          e = strb_q.pop_front();
          check("flt_xn", 32'(flt_xn), 32'(e.d));
          check("flt_en_cyc", cyc, e.cyc);
          last_xn = e.d;
        end
      end else begin
        check("flt_xn_hold", 32'(flt_xn), 32'(last_xn));
      end
      if (m_valid) begin
        if (out_q.size() == 0) check("m_valid_unexp", 32'(m_valid), 0);
        else begin
          e = out_q.pop_front();
          check("m_data", 32'(m_data), 32'(e.d));
          check("m_valid_cyc", cyc, e.cyc);
          last_m = e.d;
        end
      end else begin
        check("m_data_hold", 32'(m_data), 32'(last_m));
      end
    end
  end

  task automatic coef_word(input logic v, input logic [15:0] d, input logic [15:0] a);
    cfg_valid = v;
    cfg_coef  = d;
    @(negedge clk);
    check("load_cfg_ready", 32'(cfg_ready), 1);
    check("load_s_ready", 32'(s_ready), 0);
    check("load_busy", 32'(busy), 1);
    if (v) coef_q.push_back('{d: d, a: a, cyc: cyc + 1});
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic offer_sample(input logic v, input logic [15:0] x, input logic [15:0] y,
                              input logic run);
    s_valid = v;
    s_data  = x;
    run_en  = run;
    @(negedge clk);
    check("run_s_ready", 32'(s_ready), 1);
    check("run_busy", 32'(busy), 1);
    if (v) begin
      hs_cyc = cyc;
      strb_q.push_back('{d: x, a: 16'h0, cyc: cyc + 1});
      out_q.push_back('{d: y, a: 16'h0, cyc: cyc + 3});
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int k = 0; k < max_cyc && (coef_q.size() + strb_q.size() + out_q.size()) > 0; k++)
      @(posedge clk);
    #1;
    check("drain", coef_q.size() + strb_q.size() + out_q.size(), 0);
  endtask

  task automatic load_all(input logic [15:0] base);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 5 == 3) coef_word(1'b0, 16'hBEEF, 16'h0);
      coef_word(1'b1, base + 16'(i), 16'(i));
    end
    @(negedge clk);
    check("load_end_busy", 32'(busy), 0);
    check("load_end_cfg_ready", 32'(cfg_ready), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec[0] = '{1'b1, 16'd100,    16'd301};
    vec[1] = '{1'b1, 16'(-200),  16'(-599)};
    vec[2] = '{1'b0, 16'h0,      16'h0};
    vec[3] = '{1'b1, 16'd300,    16'd901};
    vec[4] = '{1'b1, 16'(-400),  16'(-1199)};
    vec[5] = '{1'b1, 16'd500,    16'd1501};
    vec[6] = '{1'b0, 16'h0,      16'h0};
    vec[7] = '{1'b1, 16'(-600),  16'(-1799)};
    vec[8] = '{1'b1, 16'd700,    16'd2101};
    vec[9] = '{1'b1, 16'(-800),  16'(-2399)};

    rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_coef = 0;
    run_en = 0; s_valid = 0; s_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // cfg_start and run_en together: LOAD wins; run_en held into LOAD is ignored
    cfg_start = 1'b1;
    run_en    = 1'b1;
    @(negedge clk);
    check("prio_idle_busy", 32'(busy), 0);
    check("prio_idle_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) run_en = 1'b0;
      if (i % 4 == 1) coef_word(1'b0, 16'hBEEF, 16'h0);
      coef_word(1'b1, 16'(i + 1), 16'(i));
    end
    @(negedge clk);
    check("load1_end_busy", 32'(busy), 0);
    check("load1_end_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    drain(5);

    // Stream table, then stop with a sample offered in the same cycle
    run_en = 1'b1;
    @(negedge clk);
    check("stream_idle_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    foreach (vec[i]) offer_sample(vec[i].v, vec[i].x, vec[i].y, 1'b1);
    offer_sample(1'b1, 16'd900, 16'd2701, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      strb_q.push_back('{d: 16'h0, a: 16'h0, cyc: hs_cyc + 1 + k});
      out_q.push_back('{d: 16'h1, a: 16'h0, cyc: hs_cyc + 3 + k});
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("flush_busy", 32'(busy), 1);
      check("flush_s_ready", 32'(s_ready), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("flush_end_busy", 32'(busy), 0);
    @(posedge clk); #1;
    drain(20);

    // Reset while streaming: in-flight strobes and outputs are dropped
    run_en = 1'b1;
    @(posedge clk); #1;
    offer_sample(1'b1, 16'd7, 16'd22, 1'b1);
    offer_sample(1'b1, 16'd9, 16'd28, 1'b1);
    s_valid = 1'b1;
    s_data  = 16'd55;
    rst     = 1'b1;
    coef_q.delete(); strb_q.delete(); out_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) check_zero("run_rst");
      @(posedge clk); #1;
    end
    rst = 1'b0; run_en = 1'b0; s_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 0);
      @(posedge clk); #1;
    end

    // Reset partway through a load, then a full load restarting at tap 0
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) coef_word(1'b1, 16'h00A0 + 16'(i), 16'(i));
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_coef  = 16'hFFFF;
    rst       = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k > 0) check_zero("load_rst");
      @(posedge clk); #1;
    end
    rst = 1'b0; cfg_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_load_rst_busy", 32'(busy), 0);
      @(posedge clk); #1;
    end
    load_all(16'h0100);
    drain(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
